// File: rtl/maindec_pkg.sv
// Shared encodings and the control bundle for the registered MIPS main decoder.
// MAINDEC_CP0_EN adds the CP0 fields (cp0write, eret) to the bundle.
package maindec_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_SLLV    = 6'b000100;
    localparam logic [5:0] FN_SRLV    = 6'b000110;
    localparam logic [5:0] FN_SRAV    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    localparam logic [4:0] RS_MFC0    = 5'b00000;
    localparam logic [4:0] RS_MTC0    = 5'b00100;
    localparam logic [4:0] RS_ERET    = 5'b10000;

    typedef enum logic [1:0] {
        MEMTOREG_ALU = 2'b00,
        MEMTOREG_MEM = 2'b01,
        MEMTOREG_HI  = 2'b10,
        MEMTOREG_LO  = 2'b11
    } memtoreg_e;

    typedef struct packed {
        logic      regwrite;
        logic      regdst;
        logic      alusrc;
        logic      branch;
        logic      memwrite;
        memtoreg_e memtoreg;
        logic      gprtohi;
        logic      gprtolo;
        logic      jump;
        logic      jumpr;
        logic      write_al;
        logic      invalid;
`ifdef MAINDEC_CP0_EN
        logic      cp0write;
        logic      eret;
`endif
    } ctrl_t;

endpackage

// File: rtl/maindec_comb.sv
// Pure combinational instruction -> control bundle decode, plus HI/LO class flags.
// MAINDEC_CP0_EN enables decoding of MTC0/MFC0/ERET; otherwise COP0 is reserved.
module maindec_comb
    import maindec_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        hilo_op,
    output logic        mult_op,
    output logic        div_op
);
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign funct       = instr[5:0];
    assign unused_bits = ^{rs, instr[15:6]};

    always_comb begin
        ctrl    = '0;
        hilo_op = 1'b0;
        mult_op = 1'b0;
        div_op  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        ctrl.regwrite = 1'b1;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = 1'b1;
                        ctrl.gprtohi  = 1'b1;
                        ctrl.gprtolo  = 1'b1;
                        hilo_op       = 1'b1;
                        mult_op       = (funct == FN_MULT) || (funct == FN_MULTU);
                        div_op        = (funct == FN_DIV)  || (funct == FN_DIVU);
                    end
                    FN_MFHI, FN_MFLO: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.memtoreg = (funct == FN_MFHI) ? MEMTOREG_HI : MEMTOREG_LO;
                        hilo_op       = 1'b1;
                    end
                    FN_MTHI: begin
                        ctrl.gprtohi = 1'b1;
                        hilo_op      = 1'b1;
                    end
                    FN_MTLO: begin
                        ctrl.gprtolo = 1'b1;
                        hilo_op      = 1'b1;
                    end
                    FN_JR:   ctrl.jumpr = 1'b1;
                    FN_JALR: begin
                        ctrl.jumpr    = 1'b1;
                        ctrl.regwrite = 1'b1;
                    end
                    FN_SYSCALL, FN_BREAK: ctrl = '0;
                    default: ctrl.invalid = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ: ctrl.branch = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        ctrl.branch   = 1'b1;
                        ctrl.regwrite = 1'b1;
                        ctrl.write_al = 1'b1;
                    end
                    default: ctrl.invalid = 1'b1;
                endcase
            end
            OP_J: ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.regwrite = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.write_al = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl.branch = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            // Loads keep the legacy memwrite-as-memory-enable meaning.
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.memtoreg = MEMTOREG_MEM;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
`ifdef MAINDEC_CP0_EN
            OP_COP0: begin
                case (rs)
                    RS_MTC0: ctrl.cp0write = 1'b1;
                    RS_MFC0: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = 1'b1;
                    end
                    RS_ERET: ctrl.eret = 1'b1;
                    default: ctrl.invalid = 1'b1;
                endcase
            end
`endif
            default: ctrl.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/maindec_pipe.sv
// Registered main decoder: ID/EX control register with valid/ready handshake and HI/LO interlock.
// MAINDEC_CP0_EN adds the ex_cp0write/ex_eret outputs and CP0 decode.
module maindec_pipe
    import maindec_pkg::*;
#(
    parameter int MULT_LAT = 1,
    parameter int DIV_LAT  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_regdst,
    output logic        ex_alusrc,
    output logic        ex_branch,
    output logic        ex_memwrite,
    output logic [1:0]  ex_memtoreg,
    output logic        ex_gprtohi,
    output logic        ex_gprtolo,
    output logic        ex_jump,
    output logic        ex_jumpr,
    output logic        ex_write_al,
    output logic        ex_invalid,
`ifdef MAINDEC_CP0_EN
    output logic        ex_cp0write,
    output logic        ex_eret,
`endif
    output logic        hilo_busy
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    ctrl_t            dec_ctrl;
    ctrl_t            ex_ctrl;
    logic             hilo_op;
    logic             mult_op;
    logic             div_op;
    logic             hazard;
    logic             accept;
    logic [CNT_W-1:0] busy_cnt;

    maindec_comb u_comb (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .hilo_op (hilo_op),
        .mult_op (mult_op),
        .div_op  (div_op)
    );

    assign hilo_busy = (busy_cnt != '0);
    assign hazard    = hilo_busy & hilo_op;
    assign id_ready  = (~ex_valid | ex_ready) & ~hazard & ~flush;
    assign accept    = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (ex_valid && !ex_ready) begin
            ex_valid <= ex_valid;
            ex_ctrl  <= ex_ctrl;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_ctrl  <= dec_ctrl;
        end else begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end
    end

    // Counter runs regardless of EX backpressure: it tracks the multiplier, not the pipe.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_cnt <= '0;
        end else if (accept && mult_op) begin
            busy_cnt <= CNT_W'(MULT_LAT);
        end else if (accept && div_op) begin
            busy_cnt <= CNT_W'(DIV_LAT);
        end else if (hilo_busy) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
        end
    end

    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_regdst   = ex_ctrl.regdst;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_gprtohi  = ex_ctrl.gprtohi;
    assign ex_gprtolo  = ex_ctrl.gprtolo;
    assign ex_jump     = ex_ctrl.jump;
    assign ex_jumpr    = ex_ctrl.jumpr;
    assign ex_write_al = ex_ctrl.write_al;
    assign ex_invalid  = ex_ctrl.invalid;
`ifdef MAINDEC_CP0_EN
    assign ex_cp0write = ex_ctrl.cp0write;
    assign ex_eret     = ex_ctrl.eret;
`endif

endmodule

// File: tb/tb_maindec_pipe.sv
// Self-checking bench for maindec_pipe: behavioural model compared every cycle plus directed literal checks.
// Builds with or without MAINDEC_CP0_EN.
module tb_maindec_pipe;
    localparam int MULT_LAT = 1;
    localparam int DIV_LAT  = 32;

    localparam logic [31:0] I_ADD  = 32'h0043_0820;
    localparam logic [31:0] I_LW   = 32'h8FA8_0004;
    localparam logic [31:0] I_DIV  = 32'h0043_001A;
    localparam logic [31:0] I_MFHI = 32'h0000_2010;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;
    localparam logic [31:0] I_MTC0 = 32'h4080_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        id_valid;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic        ex_regwrite, ex_regdst, ex_alusrc, ex_branch, ex_memwrite;
    logic [1:0]  ex_memtoreg;
    logic        ex_gprtohi, ex_gprtolo, ex_jump, ex_jumpr, ex_write_al, ex_invalid;
    logic        cp0w, eret;
    logic        hilo_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    maindec_pipe #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .ex_ready    (ex_ready),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_regwrite (ex_regwrite),
        .ex_regdst   (ex_regdst),
        .ex_alusrc   (ex_alusrc),
        .ex_branch   (ex_branch),
        .ex_memwrite (ex_memwrite),
        .ex_memtoreg (ex_memtoreg),
        .ex_gprtohi  (ex_gprtohi),
        .ex_gprtolo  (ex_gprtolo),
        .ex_jump     (ex_jump),
        .ex_jumpr    (ex_jumpr),
        .ex_write_al (ex_write_al),
        .ex_invalid  (ex_invalid),
`ifdef MAINDEC_CP0_EN
        .ex_cp0write (cp0w),
        .ex_eret     (eret),
`endif
        .hilo_busy   (hilo_busy)
    );

`ifndef MAINDEC_CP0_EN
    assign cp0w = 1'b0;
    assign eret = 1'b0;
`endif

    // Bundle layout: cp0write eret regwrite regdst alusrc branch memwrite memtoreg[1:0]
    //                gprtohi gprtolo jump jumpr write_al invalid
    logic [14:0] dut_vec;
    assign dut_vec = {cp0w, eret, ex_regwrite, ex_regdst, ex_alusrc, ex_branch, ex_memwrite,
                      ex_memtoreg, ex_gprtohi, ex_gprtolo, ex_jump, ex_jumpr, ex_write_al, ex_invalid};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected bundle straight from the instruction-class table.
    function automatic logic [14:0] md(input logic [31:0] iw);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        op = iw[31:26]; fn = iw[5:0]; rs = iw[25:21]; rt = iw[20:16];
        case (op)
            6'h00: case (fn)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B:                      return 15'h1000;
                6'h18, 6'h19, 6'h1A, 6'h1B:        return 15'h1830;
                6'h10:                             return 15'h1080;
                6'h12:                             return 15'h10C0;
                6'h11:                             return 15'h0020;
                6'h13:                             return 15'h0010;
                6'h08:                             return 15'h0004;
                6'h09:                             return 15'h1004;
                6'h0C, 6'h0D:                      return 15'h0000;
                default:                           return 15'h0001;
            endcase
            6'h01: case (rt)
                5'h00, 5'h01:                      return 15'h0200;
                5'h10, 5'h11:                      return 15'h1202;
                default:                           return 15'h0001;
            endcase
            6'h02:                                 return 15'h0008;
            6'h03:                                 return 15'h100A;
            6'h04, 6'h05, 6'h06, 6'h07:            return 15'h0200;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:            return 15'h1C00;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:     return 15'h1540;
            6'h28, 6'h29, 6'h2B:                   return 15'h0500;
`ifdef MAINDEC_CP0_EN
            6'h10: case (rs)
                5'h04:                             return 15'h4000;
                5'h00:                             return 15'h1800;
                5'h10:                             return 15'h2000;
                default:                           return 15'h0001;
            endcase
`endif
            default:                               return 15'h0001;
        endcase
    endfunction

    function automatic bit is_hilo(input logic [31:0] iw);
        return (iw[31:26] == 6'h00) &&
               (iw[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    // Model state: what the EX register and busy time must be.
    bit          m_init = 1'b0;
    bit          m_valid;
    logic [14:0] m_vec;
    int          m_cnt;

    function automatic bit m_rdy();
        return (!m_valid || ex_ready) && !(m_cnt > 0 && is_hilo(instr)) && !flush;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        acc = id_valid && m_rdy();
        if (rst) begin
            m_init = 1'b1; m_valid = 1'b0; m_vec = '0; m_cnt = 0;
        end else begin
            if (flush) begin
                m_valid = 1'b0; m_vec = '0;
            end else if (!(m_valid && !ex_ready)) begin
                m_valid = acc;
                m_vec   = acc ? md(instr) : 15'h0;
            end
            if (flush)                                          m_cnt = 0;
            else if (acc && instr[31:26] == 0 && instr[5:1] == 5'b01100) m_cnt = MULT_LAT;
            else if (acc && instr[31:26] == 0 && instr[5:1] == 5'b01101) m_cnt = DIV_LAT;
            else if (m_cnt > 0)                                 m_cnt = m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("ex_valid",  {31'b0, ex_valid},     {31'b0, m_valid});
            chk("bundle",    {17'b0, dut_vec},      {17'b0, m_vec});
            chk("hilo_busy", {31'b0, hilo_busy},    {31'b0, (m_cnt != 0)});
            chk("id_ready",  {31'b0, id_ready},     {31'b0, m_rdy()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vecs [22] = '{
        32'h0800_0010, 32'h0C00_0010, 32'h1043_0004, 32'h0450_0004, 32'h0441_0004,
        32'h0442_0004, 32'hAFA8_0004, 32'h3443_0005, 32'h0040_0011, 32'h0043_0018,
        32'h0000_4012, 32'h0040_0013, 32'h03E0_0008, 32'h0040_F809, 32'h0000_000C,
        32'h0000_0001, 32'h0043_001B, 32'h0040_0011, 32'h4200_0018, 32'h4002_2000,
        32'h3C01_1234, 32'h0002_1042
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int busy_seen;
        bit done;
        rst = 1'b1; instr = 32'h0; id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_busy", {31'b0, hilo_busy}, 32'd0);
        chk("rst_bundle", {17'b0, dut_vec}, 32'd0);

        // Pin the model against hand-decoded words.
        chk("md_add",  {17'b0, md(I_ADD)},  32'h1000);
        chk("md_lw",   {17'b0, md(I_LW)},   32'h1540);
        chk("md_div",  {17'b0, md(I_DIV)},  32'h1830);
        chk("md_mfhi", {17'b0, md(I_MFHI)}, 32'h1080);
        chk("md_bad",  {17'b0, md(I_BAD)},  32'h0001);

        // Decode add then lw
        instr = I_ADD; id_valid = 1'b1; tick();
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_regwrite", {31'b0, ex_regwrite}, 32'd1);
        chk("add_regdst", {31'b0, ex_regdst}, 32'd0);
        chk("add_memtoreg", {30'b0, ex_memtoreg}, 32'd0);
        instr = I_LW; tick();
        chk("lw_regwrite", {31'b0, ex_regwrite}, 32'd1);
        chk("lw_alusrc", {31'b0, ex_alusrc}, 32'd1);
        chk("lw_memtoreg", {30'b0, ex_memtoreg}, 32'd1);

        // Backpressure: hold an add for 3 cycles
        instr = I_ADD; tick();
        instr = I_LW; ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_id_ready", {31'b0, id_ready}, 32'd0);
            tick();
            chk("bp_hold_valid", {31'b0, ex_valid}, 32'd1);
            chk("bp_hold_memtoreg", {30'b0, ex_memtoreg}, 32'd0);
        end
        ex_ready = 1'b1; #1;
        chk("bp_release_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("bp_lw_loaded", {30'b0, ex_memtoreg}, 32'd1);
        id_valid = 1'b0;

        // DIV followed by dependent MFHI
        instr = I_DIV; id_valid = 1'b1; tick();
        chk("div_gprtohi", {31'b0, ex_gprtohi}, 32'd1);
        instr = I_MFHI;
        n = 0; busy_seen = 0;
        #1;
        while (!id_ready && n < 50) begin
            busy_seen += int'(hilo_busy);
            tick(); #1;
            n++;
        end
        chk("div_wait_cycles", n, 32);
        chk("div_busy_cycles", busy_seen, 32);
        tick();
        chk("mfhi_valid", {31'b0, ex_valid}, 32'd1);
        chk("mfhi_memtoreg", {30'b0, ex_memtoreg}, 32'd2);
        id_valid = 1'b0;

        // Flush racing an accept with the counter at 5
        instr = I_DIV; id_valid = 1'b1; tick();
        id_valid = 1'b0;
        repeat (27) tick();
        chk("flush_pre_busy", {31'b0, hilo_busy}, 32'd1);
        instr = I_ADD; id_valid = 1'b1; flush = 1'b1; #1;
        chk("flush_id_ready", {31'b0, id_ready}, 32'd0);
        tick();
        chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_busy", {31'b0, hilo_busy}, 32'd0);
        flush = 1'b0; id_valid = 1'b0;

        // Reserved instruction and COP0
        instr = I_BAD; id_valid = 1'b1; tick();
        chk("bad_valid", {31'b0, ex_valid}, 32'd1);
        chk("bad_bundle", {17'b0, dut_vec}, 32'h0001);
        instr = I_MTC0; tick();
`ifdef MAINDEC_CP0_EN
        chk("mtc0_cp0write", {31'b0, cp0w}, 32'd1);
        chk("mtc0_invalid", {31'b0, ex_invalid}, 32'd0);
`else
        chk("mtc0_invalid", {31'b0, ex_invalid}, 32'd1);
`endif
        id_valid = 1'b0;

        // Reset in the middle of a divide
        instr = I_DIV; id_valid = 1'b1; tick();
        id_valid = 1'b0;
        repeat (22) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rstdiv_busy", {31'b0, hilo_busy}, 32'd0);
        chk("rstdiv_ex_valid", {31'b0, ex_valid}, 32'd0);
        instr = I_MFHI; id_valid = 1'b1; #1;
        chk("rstdiv_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("rstdiv_mfhi", {30'b0, ex_memtoreg}, 32'd2);
        id_valid = 1'b0;

        // Mixed instruction classes with random EX backpressure; model checks each cycle
        foreach (vecs[i]) begin
            instr = vecs[i]; id_valid = 1'b1; done = 1'b0;
            for (int k = 0; k < 80 && !done; k++) begin
                ex_ready = ($urandom_range(0, 3) != 0);
                #1;
                done = id_ready;
                tick();
            end
            chk("accept_bound", {31'b0, done}, 32'd1);
            id_valid = 1'b0; ex_ready = 1'b1;
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
